mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one single-port RAM between instruction fetch and data memory.
// Data has priority; a saturating counter bounds how long fetch can be starved.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch port (read only)
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data memory port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // shared RAM port
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } tag_t;

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             starved;
  tag_t             tag_in;
  tag_t             tag_q [RD_LAT];

  // Grant selection, RAM port steering and starvation counter update
  always_comb begin
    if_gnt         = 1'b0;
    dm_gnt         = 1'b0;
    starved        = (starve_cnt == CNT_MAX);
    starve_cnt_nxt = starve_cnt;

    if (rst_n) begin
      dm_gnt = dm_req && !(if_req && starved);
      if_gnt = if_req && !dm_gnt;
    end

    ram_addr     = dm_gnt ? dm_addr : if_addr;
    ram_wdata    = dm_wdata;
    ram_wren     = dm_gnt & dm_we;
    ram_rden     = if_gnt | (dm_gnt & ~dm_we);
    tag_in.vld   = ram_rden;
    tag_in.owner = dm_gnt ? OWN_DM : OWN_IF;

    if (!if_req || if_gnt) begin
      starve_cnt_nxt = '0;
    end else if (dm_gnt && !starved) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // Counter and read-tag shift pipeline; reset discards reads in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      starve_cnt <= starve_cnt_nxt;
      tag_q[0]   <= tag_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign if_rvalid = tag_q[RD_LAT-1].vld && (tag_q[RD_LAT-1].owner == OWN_IF);
  assign dm_rvalid = tag_q[RD_LAT-1].vld && (tag_q[RD_LAT-1].owner == OWN_DM);
  assign if_rdata  = ram_rdata;
  assign dm_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances (RD_LAT=1 and RD_LAT=2) driven with
// identical directed traffic, each with its own RAM model and response queue.
module tb_mem_arbiter;

  localparam int G_NONE = 0;
  localparam int G_IF   = 1;
  localparam int G_DM   = 2;

  typedef struct {
    logic        dm;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [7:0]  if_addr, dm_addr;
  logic [31:0] dm_wdata;

  logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_ram_rden, a_ram_wren;
  logic [31:0] a_if_rdata, a_dm_rdata, a_ram_wdata, a_ram_rdata;
  logic [7:0]  a_ram_addr;
  logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_ram_rden, b_ram_wren;
  logic [31:0] b_if_rdata, b_dm_rdata, b_ram_wdata, b_ram_rdata;
  logic [7:0]  b_ram_addr;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] exp_mem [256];
  logic [31:0] a_r1, b_r1, b_r2;

  rsp_t sb_a[$];
  rsp_t sb_b[$];
  rsp_t ra, rb;
  int   cyc_n = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rden(a_ram_rden),
    .ram_wren(a_ram_wren), .ram_rdata(a_ram_rdata)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(2), .STARVE_MAX(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rden(b_ram_rden),
    .ram_wren(b_ram_wren), .ram_rdata(b_ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h0050_0093 : (32'hC0DE_0000 | 32'(i));
  endfunction

  // RAM models: write-before-read, latency 1 (a) and 2 (b)
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (cyc_n == 0) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
    end else begin
      if (a_ram_rden) a_r1 <= mem_a[a_ram_addr];
      if (a_ram_wren) mem_a[a_ram_addr] <= a_ram_wdata;
      if (b_ram_rden) b_r1 <= mem_b[b_ram_addr];
      if (b_ram_wren) mem_b[b_ram_addr] <= b_ram_wdata;
      b_r2 <= b_r1;
    end
  end
  assign a_ram_rdata = a_r1;
  assign b_ram_rdata = b_r2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc_n, act, exp);
    end
  endtask

  // Response monitors: pop on rvalid; an entry past its due cycle is a missing response
  always @(negedge clk) begin
    if (a_if_rvalid || a_dm_rvalid) begin
      if (sb_a.size() == 0) begin
        chk("rv_unexpected_a", 64'({a_if_rvalid, a_dm_rvalid}), 64'(2'b00));
      end else begin
        ra = sb_a.pop_front();
        chk("rv_owner_a", 64'({a_if_rvalid, a_dm_rvalid}), 64'({~ra.dm, ra.dm}));
        chk("rv_data_a", 64'(ra.dm ? a_dm_rdata : a_if_rdata), 64'(ra.data));
        chk("rv_cycle_a", 64'(cyc_n), 64'(ra.cyc));
      end
    end else if (sb_a.size() != 0 && sb_a[0].cyc <= cyc_n) begin
      ra = sb_a.pop_front();
      chk("rv_missing_a", 64'({a_if_rvalid, a_dm_rvalid}), 64'({~ra.dm, ra.dm}));
    end
  end

  always @(negedge clk) begin
    if (b_if_rvalid || b_dm_rvalid) begin
      if (sb_b.size() == 0) begin
        chk("rv_unexpected_b", 64'({b_if_rvalid, b_dm_rvalid}), 64'(2'b00));
      end else begin
        rb = sb_b.pop_front();
        chk("rv_owner_b", 64'({b_if_rvalid, b_dm_rvalid}), 64'({~rb.dm, rb.dm}));
        chk("rv_data_b", 64'(rb.dm ? b_dm_rdata : b_if_rdata), 64'(rb.data));
        chk("rv_cycle_b", 64'(cyc_n), 64'(rb.cyc));
      end
    end else if (sb_b.size() != 0 && sb_b[0].cyc <= cyc_n) begin
      rb = sb_b.pop_front();
      chk("rv_missing_b", 64'({b_if_rvalid, b_dm_rvalid}), 64'({~rb.dm, rb.dm}));
    end
  end

  // One cycle of stimulus with its hand-computed grant; read grants queue an expected response
  task automatic cyc(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                     input logic [7:0] da, input logic [31:0] dd, input int eg);
    rsp_t r;
    logic exp_rd, exp_wr;
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    exp_rd = (eg == G_IF) || (eg == G_DM && !dw);
    exp_wr = (eg == G_DM) && dw;
    @(negedge clk);
    chk("gnt_a", 64'({a_if_gnt, a_dm_gnt}), 64'({eg == G_IF, eg == G_DM}));
    chk("gnt_b", 64'({b_if_gnt, b_dm_gnt}), 64'({eg == G_IF, eg == G_DM}));
    chk("ram_ctl_a", 64'({a_ram_rden, a_ram_wren}), 64'({exp_rd, exp_wr}));
    chk("ram_ctl_b", 64'({b_ram_rden, b_ram_wren}), 64'({exp_rd, exp_wr}));
    if (eg != G_NONE) begin
      chk("ram_addr_a", 64'(a_ram_addr), 64'(eg == G_DM ? da : ia));
      chk("ram_addr_b", 64'(b_ram_addr), 64'(eg == G_DM ? da : ia));
    end
    if (exp_wr) begin
      chk("ram_wdata_a", 64'(a_ram_wdata), 64'(dd));
      exp_mem[da] = dd;
    end
    if (exp_rd) begin
      r.dm   = (eg == G_DM);
      r.data = exp_mem[(eg == G_DM) ? da : ia];
      r.cyc  = cyc_n + 1;
      sb_a.push_back(r);
      r.cyc  = cyc_n + 2;
      sb_b.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, G_NONE);
  endtask

  // Hold reset with both requests high; everything in flight is dropped
  task automatic do_reset(input int n);
    rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    sb_a.delete();
    sb_b.delete();
    repeat (n) begin
      @(negedge clk);
      chk("reset_out_a", 64'({a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid, a_ram_rden, a_ram_wren}), 64'(0));
      chk("reset_out_b", 64'({b_if_gnt, b_dm_gnt, b_if_rvalid, b_dm_rvalid, b_ram_rden, b_ram_wren}), 64'(0));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 8'h00; dm_addr = 8'h00; dm_wdata = 32'h0;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    #1;
    do_reset(2);

    // single fetch, granted in the first cycle out of reset
    cyc(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0, G_IF);
    idle(1);
    // collision: data wins, fetch next cycle
    cyc(1'b1, 8'h08, 1'b1, 1'b0, 8'h10, 32'h0, G_DM);
    cyc(1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 32'h0, G_IF);
    idle(1);
    // starvation: DM DM DM IF DM DM DM IF
    cyc(1'b1, 8'h0C, 1'b1, 1'b0, 8'h30, 32'h0, G_DM);
    cyc(1'b1, 8'h0C, 1'b1, 1'b0, 8'h31, 32'h0, G_DM);
    cyc(1'b1, 8'h0C, 1'b1, 1'b0, 8'h32, 32'h0, G_DM);
    cyc(1'b1, 8'h0C, 1'b1, 1'b0, 8'h33, 32'h0, G_IF);
    cyc(1'b1, 8'h0D, 1'b1, 1'b0, 8'h33, 32'h0, G_DM);
    cyc(1'b1, 8'h0D, 1'b1, 1'b0, 8'h34, 32'h0, G_DM);
    cyc(1'b1, 8'h0D, 1'b1, 1'b0, 8'h35, 32'h0, G_DM);
    cyc(1'b1, 8'h0D, 1'b0, 1'b0, 8'h00, 32'h0, G_IF);
    idle(1);
    // store then load to the same address
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'hDEAD_BEEF, G_DM);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 32'h0, G_DM);
    idle(1);
    // streaming: alternating IF/DM reads back-to-back
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 8'h00, 32'h0, G_IF);
      else            cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'(8'h50 + i), 32'h0, G_DM);
    end
    // store immediately followed by a fetch of the same word
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h60, 32'h1234_5678, G_DM);
    cyc(1'b1, 8'h60, 1'b0, 1'b0, 8'h00, 32'h0, G_IF);
    idle(3);
    // saturate the counter, then reset with reads in flight
    cyc(1'b1, 8'h0F, 1'b1, 1'b0, 8'h70, 32'h0, G_DM);
    cyc(1'b1, 8'h0F, 1'b1, 1'b0, 8'h71, 32'h0, G_DM);
    cyc(1'b1, 8'h0F, 1'b1, 1'b0, 8'h72, 32'h0, G_DM);
    do_reset(2);
    // counter restarts from zero: three more data grants before fetch wins
    cyc(1'b1, 8'h0F, 1'b1, 1'b0, 8'h73, 32'h0, G_DM);
    cyc(1'b1, 8'h0F, 1'b1, 1'b0, 8'h74, 32'h0, G_DM);
    cyc(1'b1, 8'h0F, 1'b1, 1'b0, 8'h75, 32'h0, G_DM);
    cyc(1'b1, 8'h0F, 1'b1, 1'b0, 8'h76, 32'h0, G_IF);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h76, 32'h0, G_DM);
    idle(4);

    chk("drain_a", 64'(sb_a.size()), 64'(0));
    chk("drain_b", 64'(sb_b.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
